// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between pipeline_hazard_ctrl and the pipeline registers it steers.
// The master side is the pipeline; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned CNT_W  = 32
);
    logic [NSTAGE-1:0] busy;
    logic              load_use;
    logic              redirect;
    logic              trap;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              redirect_pend;
    logic [CNT_W-1:0]  stall_cycles;
    logic              hang;

    modport master (
        output busy, load_use, redirect, trap,
        input  stall, flush, redirect_pend, stall_cycles, hang
    );

    modport slave (
        input  busy, load_use, redirect, trap,
        output stall, flush, redirect_pend, stall_cycles, hang
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Per-stage stall/flush generation for the in-order core, with deferred F flush
// behind an outstanding fetch, a saturating stall-cycle counter and a hang watchdog.
module pipeline_hazard_ctrl #(
    parameter int unsigned NSTAGE      = 5,
    parameter int unsigned HAZ_STAGE   = 2,
    parameter int unsigned REDIR_STAGE = 3,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   resetn,
    pipeline_hazard_ctrl_if.slave  hif
);
    localparam int unsigned SW    = $clog2(NSTAGE + 1);
    localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]    HAZ_IDX  = SW'(HAZ_STAGE);
    localparam logic [SW-1:0]    REDIR_IDX = SW'(REDIR_STAGE);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [RUN_W-1:0]  r_run;
    logic              r_hang;

    logic              w_busy_vld;
    logic [SW-1:0]     w_busy_top;
    logic              w_src_vld;
    logic [SW-1:0]     w_src;
    logic              w_redir_acc;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_flush;

    // Stall source: highest busy stage, promoted to HAZ_STAGE by a load-use hazard.
    always_comb begin
        w_busy_vld = 1'b0;
        w_busy_top = '0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            if (hif.busy[i]) begin
                w_busy_vld = 1'b1;
                w_busy_top = SW'(i);
            end
        end
        w_src_vld = w_busy_vld;
        w_src     = w_busy_top;
        if (hif.load_use && (!w_busy_vld || (HAZ_IDX > w_busy_top))) begin
            w_src_vld = 1'b1;
            w_src     = HAZ_IDX;
        end
        w_redir_acc = hif.redirect && !hif.trap && (!w_src_vld || (w_src < REDIR_IDX));
    end

    always_comb begin
        w_stall     = '0;
        w_flush     = '0;
        w_state_nxt = r_state;
        if (!resetn) begin
            w_state_nxt = ST_IDLE;
        end else if (hif.trap) begin
            for (int unsigned j = 0; j < NSTAGE; j++) begin
                w_stall[j] = w_busy_vld && (j <= 32'(w_busy_top));
                w_flush[j] = !hif.busy[j];
            end
            // A non-busy F is flushed by the trap itself, so no deferral is left over.
            w_state_nxt = hif.busy[1] ? ST_PEND : ST_IDLE;
        end else begin
            for (int unsigned j = 0; j < NSTAGE; j++) begin
                w_stall[j] = w_src_vld && (j <= 32'(w_src));
                if (w_src_vld && (j == 32'(w_src) + 1)) begin
                    w_flush[j] = 1'b1;
                end
            end
            if (w_redir_acc) begin
                for (int unsigned j = 2; j < REDIR_STAGE; j++) begin
                    w_flush[j] = 1'b1;
                end
            end
            // New and pending redirects share one F flush once the fetch returns.
            if (w_redir_acc || (r_state == ST_PEND)) begin
                if (hif.busy[1]) begin
                    w_state_nxt = ST_PEND;
                end else begin
                    w_flush[1]  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_run   <= '0;
            r_hang  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall[0]) begin
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_run != RUN_MAX) begin
                    r_run <= r_run + 1'b1;
                end
                if (r_run >= RUN_LAST) begin
                    r_hang <= 1'b1;
                end
            end else begin
                r_run <= '0;
            end
        end
    end

    assign hif.stall         = w_stall;
    assign hif.flush         = w_flush;
    assign hif.redirect_pend = (r_state == ST_PEND);
    assign hif.stall_cycles  = r_cnt;
    assign hif.hang          = r_hang;
endmodule
